// File: rtl/time_edit_scheduler.sv
// Edit-key front end for the HH:MM counter: sync/debounce, per-key press queue,
// round-robin command issue over valid/ready, and set-mode blink blanking. Optional AUTOREPEAT_EN.
module time_edit_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       set_mode_i,
  input  logic [3:0] key_n_i,
  input  logic [3:0] decisec_i,
  input  logic       cmd_ready_i,
  output logic       cmd_valid_o,
  output logic [1:0] cmd_op_o,
  output logic       sec_clear_o,
  output logic [3:0] pending_o,
  output logic [7:0] drop_count_o,
  output logic       blank_o
);
  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

  state_t     state_q;
  logic       cmd_valid_q;
  logic [1:0] cmd_op_q, ptr_q;
  logic [3:0] pending_q, pend_d, ev;
  logic [7:0] drop_q, drop_d;
  logic [2:0] ndrop;
  logic [8:0] dsum;
  logic       blank_q, accept, sel_found;
  logic [1:0] sel_op, idx;

  assign accept = cmd_valid_q && cmd_ready_i;

`ifdef AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
`else
  logic unused_rpt;
  assign unused_rpt = (REPEAT_DELAY > REPEAT_PERIOD);
`endif

  for (genvar k = 0; k < 4; k++) begin : g_key
    logic             s1_q, s2_q, deb_q, press;
    logic [CNT_W-1:0] cnt_q;

    // press fires on the same edge the debounced level falls
    assign press = deb_q && !s2_q && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        s1_q  <= 1'b1;
        s2_q  <= 1'b1;
        deb_q <= 1'b1;
        cnt_q <= '0;
      end else begin
        s1_q <= key_n_i[k];
        s2_q <= s1_q;
        if (s2_q == deb_q) cnt_q <= '0;
        else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q <= s2_q;
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
      end
    end

`ifdef AUTOREPEAT_EN
    logic [HW-1:0] hold_q;
    logic          rpt;
    // reload so that later repeats land REPEAT_PERIOD apart
    assign rpt = set_mode_i && !deb_q && (hold_q == HW'(REPEAT_DELAY - 1));
    always_ff @(posedge clk_i) begin
      if (reset_i || deb_q || !set_mode_i) hold_q <= '0;
      else if (rpt)                        hold_q <= HW'(REPEAT_DELAY - REPEAT_PERIOD);
      else                                 hold_q <= hold_q + 1'b1;
    end
    assign ev[k] = press | rpt;
`else
    assign ev[k] = press;
`endif
  end

  always_comb begin
    pend_d = pending_q;
    ndrop  = '0;
    if (accept) pend_d[cmd_op_q] = 1'b0;
    // a press landing on the accept cycle re-arms the key instead of counting a drop
    for (int k = 0; k < 4; k++) begin
      if (ev[k]) begin
        if (pending_q[k] && !(accept && cmd_op_q == 2'(k))) ndrop = ndrop + 3'd1;
        pend_d[k] = 1'b1;
      end
    end
    if (!set_mode_i) begin
      pend_d = '0;
      ndrop  = '0;
    end
    dsum   = {1'b0, drop_q} + {6'b0, ndrop};
    drop_d = dsum[8] ? 8'hFF : dsum[7:0];
  end

  always_comb begin
    sel_found = 1'b0;
    sel_op    = ptr_q;
    idx       = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel_op    = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q <= '0;
      drop_q    <= '0;
      blank_q   <= 1'b0;
    end else begin
      pending_q <= pend_d;
      drop_q    <= drop_d;
      blank_q   <= set_mode_i && (decisec_i < 4'd5);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 2'd0;
      ptr_q       <= 2'd3;
    end else begin
      case (state_q)
        IDLE: if (set_mode_i && sel_found) begin
          cmd_op_q    <= sel_op;
          cmd_valid_q <= 1'b1;
          state_q     <= OFFER;
        end
        OFFER: if (accept) begin
          cmd_valid_q <= 1'b0;
          ptr_q       <= cmd_op_q;
          state_q     <= GAP;
        end else if (!set_mode_i) begin
          cmd_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_op_o     = cmd_op_q;
  assign sec_clear_o  = cmd_valid_q && !cmd_op_q[1];
  assign pending_o    = pending_q;
  assign drop_count_o = drop_q;
  assign blank_o      = blank_q;
endmodule
